// File: rtl/skin_segm_pkg.sv
// Shared constants and helpers for the YCbCr skin-colour segmentation stage.
package skin_segm_pkg;

  localparam logic MODE_BINARY = 1'b0;
  localparam logic MODE_MASK   = 1'b1;

  localparam int unsigned DEF_CB_MIN = 32'd90;
  localparam int unsigned DEF_CB_MAX = 32'd140;
  localparam int unsigned DEF_CR_MIN = 32'd90;
  localparam int unsigned DEF_CR_MAX = 32'd126;
  localparam int unsigned DEF_Y_MIN  = 32'd0;

  // Mid-scale chroma value (2^(dw-1)) used for colourless masked pixels.
  function automatic int unsigned neutral_chroma(input int unsigned dw);
    return 32'd1 << (dw - 32'd1);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth, clock-enabled shift register for video sync/control bits.
module sync_delay #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_pipe [DEPTH];

  // Shift the sync word one stage per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (ce) begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/skin_segm_pipe.sv
// Two-stage YCbCr skin segmentation with frame-latched thresholds and a
// saturating per-frame skin-pixel counter.
module skin_segm_pipe
  import skin_segm_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned CNT_W      = 22,
  parameter int unsigned CB_MIN_DEF = DEF_CB_MIN,
  parameter int unsigned CB_MAX_DEF = DEF_CB_MAX,
  parameter int unsigned CR_MIN_DEF = DEF_CR_MIN,
  parameter int unsigned CR_MAX_DEF = DEF_CR_MAX,
  parameter int unsigned Y_MIN_DEF  = DEF_Y_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [DW-1:0]    in_y,
  input  logic [DW-1:0]    in_cb,
  input  logic [DW-1:0]    in_cr,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic             in_de,
  input  logic [DW-1:0]    cb_min,
  input  logic [DW-1:0]    cb_max,
  input  logic [DW-1:0]    cr_min,
  input  logic [DW-1:0]    cr_max,
  input  logic [DW-1:0]    y_min,
  input  logic             mode,
  output logic [DW-1:0]    out_y,
  output logic [DW-1:0]    out_cb,
  output logic [DW-1:0]    out_cr,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic             out_de,
  output logic [CNT_W-1:0] skin_count,
  output logic             count_valid
);

  localparam logic [DW-1:0]    NEUTRAL = DW'(neutral_chroma(DW));
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DW-1:0]    r_cb_min, r_cb_max, r_cr_min, r_cr_max, r_y_min;
  logic             r_mode, r_vsync_prev;
  logic             r_hit1, r_de1, r_mode1;
  logic [DW-1:0]    r_y1, r_cb1, r_cr1;
  logic [CNT_W-1:0] r_acc;
  logic             w_fb, w_hit;
  logic [DW-1:0]    w_oy, w_ocb, w_ocr;
  logic [2:0]       w_sync_q;

  assign w_fb  = in_vsync & ~r_vsync_prev;
  // Inverted ranges fall out naturally: no value satisfies min <= x <= max.
  assign w_hit = (in_y >= r_y_min) &&
                 (in_cb >= r_cb_min) && (in_cb <= r_cb_max) &&
                 (in_cr >= r_cr_min) && (in_cr <= r_cr_max);

  // Frame-boundary detector and threshold/mode shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_prev <= 1'b0;
      r_mode       <= MODE_BINARY;
      r_cb_min     <= DW'(CB_MIN_DEF);
      r_cb_max     <= DW'(CB_MAX_DEF);
      r_cr_min     <= DW'(CR_MIN_DEF);
      r_cr_max     <= DW'(CR_MAX_DEF);
      r_y_min      <= DW'(Y_MIN_DEF);
    end else if (ce) begin
      r_vsync_prev <= in_vsync;
      if (w_fb) begin
        r_mode   <= mode;
        r_cb_min <= cb_min;
        r_cb_max <= cb_max;
        r_cr_min <= cr_min;
        r_cr_max <= cr_max;
        r_y_min  <= y_min;
      end
    end
  end

  // Stage 1: capture compare result, mode in force and the raw pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit1  <= 1'b0;
      r_de1   <= 1'b0;
      r_mode1 <= MODE_BINARY;
      r_y1    <= '0;
      r_cb1   <= '0;
      r_cr1   <= '0;
    end else if (ce) begin
      r_hit1  <= w_hit;
      r_de1   <= in_de;
      r_mode1 <= r_mode;
      r_y1    <= in_y;
      r_cb1   <= in_cb;
      r_cr1   <= in_cr;
    end
  end

  // Output selection for stage 2.
  always_comb begin
    w_oy  = '0;
    w_ocb = '0;
    w_ocr = '0;
    if (!r_de1) begin
      w_oy  = '0;
      w_ocb = '0;
      w_ocr = '0;
    end else if (r_mode1 == MODE_BINARY) begin
      w_oy  = {DW{r_hit1}};
      w_ocb = {DW{r_hit1}};
      w_ocr = {DW{r_hit1}};
    end else if (r_hit1) begin
      w_oy  = r_y1;
      w_ocb = r_cb1;
      w_ocr = r_cr1;
    end else begin
      w_oy  = '0;
      w_ocb = NEUTRAL;
      w_ocr = NEUTRAL;
    end
  end

  // Stage 2: output pixel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y  <= '0;
      out_cb <= '0;
      out_cr <= '0;
    end else if (ce) begin
      out_y  <= w_oy;
      out_cb <= w_ocb;
      out_cr <= w_ocr;
    end
  end

  sync_delay #(.W(3), .DEPTH(2)) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .i_d   ({in_hsync, in_vsync, in_de}),
    .o_q   (w_sync_q)
  );

  assign out_hsync = w_sync_q[2];
  assign out_vsync = w_sync_q[1];
  assign out_de    = w_sync_q[0];

  // The pulse is cleared on non-enabled cycles so it spans exactly one ce cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_valid <= 1'b0;
    end else begin
      count_valid <= ce & w_fb;
    end
  end

  // Saturating skin-pixel accumulator; FB pixel seeds the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      skin_count <= '0;
    end else if (ce) begin
      if (w_fb) begin
        skin_count <= r_acc;
        r_acc      <= (w_hit && in_de) ? CNT_W'(1) : '0;
      end else if (w_hit && in_de && (r_acc != CNT_MAX)) begin
        r_acc <= r_acc + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/skin_segm_pipe.md
# skin_segm_pipe

Parametrised, pipelined YCbCr skin-colour segmentation stage with frame-synchronous threshold update and a per-frame skin-pixel counter. Sits directly after `rgb2ycbcr` and drives the HDMI output path. Generalises plain thresholding with:
- configurable data width;
- binary or masked-colour output mode;
- thresholds latched only at frame boundaries, so there is no mid-frame tearing;
- a saturating skin-area statistic per frame.

## Interface
- `DW`, 8, channel width of Y/Cb/Cr in and out.
- `CNT_W`, 22, width of frame skin-pixel counter.
- `CB_MIN_DEF`, 90, reset value of Cb lower bound shadow register.
- `CB_MAX_DEF`, 140, reset value of Cb upper bound shadow register.
- `CR_MIN_DEF`, 90, reset value of Cr lower bound shadow register.
- `CR_MAX_DEF`, 126, reset value of Cr upper bound shadow register.
- `Y_MIN_DEF`, 0, reset value of luma lower bound shadow register.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; pipeline and counters advance only when 1.
- `in_y`, `in_cb`, `in_cr`  in  DW each  input pixel.
- `in_hsync`, `in_vsync`, `in_de`  in  1 each  input sync; vsync active-high.
- `cb_min`, `cb_max`, `cr_min`, `cr_max`, `y_min`  in  DW each  live threshold inputs.
- `mode`  in  1  0 = binary, 1 = masked colour; sampled at frame boundary.
- `out_y`, `out_cb`, `out_cr`  out  DW each  output pixel.
- `out_hsync`, `out_vsync`, `out_de`  out  1 each  delayed sync.
- `skin_count`  out  CNT_W  skin pixels in last completed frame.
- `count_valid`  out  1  one-`ce`-cycle pulse when `skin_count` updates.

## Operation
- Frame boundary (FB) is the `ce` cycle where `in_vsync`=1 and the registered previous `in_vsync`=0.
- At an FB:
  - all five thresholds and `mode` are copied into shadow registers;
  - shadows take effect from the first pixel after the FB;
  - the pixel present in the FB cycle is classified with the old shadows.
- Skin hit, evaluated with inclusive bounds:
  - `y_min` ≤ Y;
  - `cb_min` ≤ Cb ≤ `cb_max`;
  - `cr_min` ≤ Cr ≤ `cr_max`.
- Inverted ranges (min > max) never hit. Comparisons are unsigned, DW bits wide.
- Binary mode output: all three channels = {DW{hit}}.
- Masked mode output:
  - hit: input pixel passes unchanged;
  - no hit: Y = 0, Cb = Cr = 2^(DW-1).
- Pixels with `in_de`=0 output all channels 0 in both modes and never count.
- Counter: increments on each `ce` cycle with `in_de`=1 and hit. It saturates at 2^CNT_W−1 and does not wrap.
- At an FB:
  - `skin_count` ← accumulated value (the FB-cycle pixel is excluded);
  - accumulator ← (FB pixel hit & de) ? 1 : 0;
  - `count_valid` pulses.
- Reset values:
  - all outputs 0, including `skin_count` and `count_valid`;
  - accumulator 0, previous-vsync register 0, `mode` shadow 0;
  - threshold shadows = *_DEF.
- Reset asserted mid-frame: all state is discarded. The first FB after release reports only the pixels seen since release.
- `ce`=0: every register holds, and `count_valid` stays 0 (a pulse is exactly one `ce` cycle long).

## Timing
- Latency: 2 `ce` cycles from input to output for pixel data and for sync. Sync stays aligned with data.
  - Stage 1: register the compare results and input pixel/sync.
  - Stage 2: output mux register.
- `skin_count` and `count_valid` are registered and assert in the cycle after the FB `ce` cycle.
- No backpressure: the block accepts one pixel per `ce` cycle, unconditionally.

## Structure
- Package `skin_segm_pkg`:
  - mode constants `MODE_BINARY` = 0 and `MODE_MASK` = 1;
  - default threshold constants;
  - neutral chroma function 2^(DW-1).
- Sub-module `sync_delay`, parameterised by width and depth (here 3 bits, depth 2). It carries hsync/vsync/de through the pipeline and is reusable by other video stages.
- Top level holds the shadow registers, the FB detector, the comparators, the output mux and the counter.

## Test plan
- After reset, with no FB and default shadows: pixel Y=100, Cb=100, Cr=100, de=1, mode input 1 → output 8'hFF×3 two cycles later. Mode is still binary because no FB has occurred.
- FB with `mode`=1 and `cb_min` set to 120, then pixel (100,100,100) → output (0,128,128). Pixel (100,130,110) → output (100,130,110).
- Change `cb_max` mid-frame to 50 → no effect until the next FB. After that FB, pixel Cb=100 → no hit.
- Frame of 640×480 de pixels, 1000 of them hits → `skin_count`=1000 and a one-cycle `count_valid` pulse one cycle after the next FB.
- CNT_W=4 with 20 hits in a frame → `skin_count`=15 (saturated). A hit pixel in the FB cycle itself starts the next frame's count at 1.
- `ce` toggling 1/0 every cycle → output equals the `ce`=1 reference stream with latency 2 `ce` cycles. Assert `rst_n` mid-frame → all outputs 0 immediately, and shadows return to defaults.
